// File: rtl/acc_alu_seq.sv
// Accumulator ALU with a radix-2 sequential shift-add multiplier and a Start/Busy/Done handshake.
// Define ACC_ALU_SAT_EN to clamp ADD/SUB/MUL/MAC results instead of wrapping.
module acc_alu_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned FRAC  = 3
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] Imm,
  input  logic [WIDTH-1:0] RegData,
  input  logic [WIDTH-1:0] SW,
  input  logic             SelImm,
  input  logic             SelSW,
  input  logic             SelRegData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ACC
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned PW   = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StMult, StWb} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             mac_q, mac_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] data;
  logic             is_mul;
  logic             last_step;

  assign data = (Imm & {WIDTH{SelImm}}) | (SW & {WIDTH{SelSW}}) |
                (RegData & {WIDTH{SelRegData}});
  assign is_mul    = (Op == 3'd3) || (Op == 3'd4);
  assign last_step = (cnt_q == CntW'(WIDTH - 1));

  function automatic logic [PW:0] sext(input logic [WIDTH-1:0] x);
    return {{(WIDTH + 1){x[WIDTH-1]}}, x};
  endfunction

  // Full-precision scaled product, one guard bit wider than the product itself.
  function automatic logic [PW:0] scale(input logic [PW-1:0] p);
    logic signed [PW:0] ext;
    ext = $signed({p[PW-1], p});
    return ext >>> FRAC;
  endfunction

  function automatic logic [WIDTH-1:0] fit(input logic [PW:0] v);
`ifdef ACC_ALU_SAT_EN
    if ((v[PW:WIDTH-1] == '0) || (v[PW:WIDTH-1] == '1)) begin
      return v[WIDTH-1:0];
    end else if (v[PW]) begin
      return {1'b1, {(WIDTH - 1){1'b0}}};
    end else begin
      return {1'b0, {(WIDTH - 1){1'b1}}};
    end
`else
    return v[WIDTH-1:0];
`endif
  endfunction

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (Start && is_mul) state_d = StMult;
      StMult:  if (last_step) state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    acc_d    = acc_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    mac_d    = mac_q;
    done_d   = 1'b0;
    busy_d   = (state_d != StIdle);
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          done_d = !is_mul;
          case (Op)
            3'd0: acc_d = data;
            3'd1: acc_d = fit(sext(acc_q) + sext(data));
            3'd2: acc_d = fit(sext(acc_q) - sext(data));
            3'd3, 3'd4: begin
              mcand_d  = {{WIDTH{data[WIDTH-1]}}, data};
              mplier_d = Imm;
              prod_d   = '0;
              cnt_d    = '0;
              mac_d    = (Op == 3'd4);
            end
            3'd5:    acc_d = '0;
            default: ;
          endcase
        end
      end
      StMult: begin
        // Multiplier MSB carries weight -2^(WIDTH-1), hence the subtract on the last step.
        if (mplier_q[0]) begin
          prod_d = last_step ? (prod_q - mcand_q) : (prod_q + mcand_q);
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
      end
      StWb: begin
        done_d = 1'b1;
        acc_d  = mac_q ? fit(sext(acc_q) + scale(prod_q)) : fit(scale(prod_q));
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      mac_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      mac_q    <= mac_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign ACC  = acc_q;

endmodule

// File: tb/tb_acc_alu_seq.sv
// Scoreboard bench for acc_alu_seq: stimulus pushes expected ACC values, a monitor checks on Done.
module tb_acc_alu_seq;

  localparam int W = 8;
  localparam int F = 3;

  logic       Clock = 1'b0;
  logic       nReset = 1'b0;
  logic       Start = 1'b0;
  logic [2:0] Op = '0;
  logic [7:0] Imm = '0, RegData = '0, SW = '0;
  logic       SelImm = 1'b0, SelSW = 1'b0, SelRegData = 1'b0;
  logic       Busy, Done;
  logic [7:0] ACC;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_acc = '0;

  acc_alu_seq #(.WIDTH(W), .FRAC(F)) dut (
    .Clock(Clock), .nReset(nReset), .Start(Start), .Op(Op), .Imm(Imm), .RegData(RegData),
    .SW(SW), .SelImm(SelImm), .SelSW(SelSW), .SelRegData(SelRegData),
    .Busy(Busy), .Done(Done), .ACC(ACC)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed integer arithmetic on the spec's rules.
  function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] d,
                                       input logic [7:0] m, input logic [7:0] a);
    longint ad, dd, md, r;
    ad = longint'($signed(a));
    dd = longint'($signed(d));
    md = longint'($signed(m));
    case (op)
      3'd0:    r = dd;
      3'd1:    r = ad + dd;
      3'd2:    r = ad - dd;
      3'd3:    r = (dd * md) >>> F;
      3'd4:    r = ad + ((dd * md) >>> F);
      3'd5:    r = 0;
      default: r = ad;
    endcase
`ifdef ACC_ALU_SAT_EN
    if (op inside {[3'd1:3'd4]}) begin
      if (r > 127) r = 127;
      if (r < -128) r = -128;
    end
`endif
    return r[7:0];
  endfunction

  always @(negedge Clock) begin
    if (nReset && Done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done=1 required no pending op at %0t", $time);
      end else begin
        check("acc_on_done", {24'b0, ACC}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  // Called at a falling edge with the DUT idle; returns at the falling edge where Done is seen.
  // ev_kind 1: raise Start (LOAD 5) at busy cycle ev_at; ev_kind 2: assert reset there.
  task automatic run_op(input logic [2:0] op, input logic [7:0] imm, input logic [7:0] rd,
                        input logic [7:0] sw, input logic si, input logic ss, input logic sr,
                        input int ev_at, input int ev_kind);
    logic [7:0] d, prev, e;
    int n, guard;
    bit mul;
    Op = op; Imm = imm; RegData = rd; SW = sw;
    SelImm = si; SelSW = ss; SelRegData = sr;
    Start = 1'b1;
    d = (imm & {8{si}}) | (sw & {8{ss}}) | (rd & {8{sr}});
    mul = (op == 3'd3) || (op == 3'd4);
    prev = model_acc;
    e = model(op, d, imm, model_acc);
    exp_q.push_back(e);
    model_acc = e;
    @(negedge Clock);
    Start = 1'b0;
    Op = 3'($urandom); Imm = 8'($urandom); RegData = 8'($urandom); SW = 8'($urandom);
    SelImm = 1'($urandom); SelSW = 1'($urandom); SelRegData = 1'($urandom);
    if (!mul) begin
      check("single_done", {31'b0, Done}, 32'd1);
      check("single_busy", {31'b0, Busy}, 32'd0);
      return;
    end
    n = 0;
    guard = 0;
    while (!Done && guard < 4 * W) begin
      if (Busy) n++;
      check("acc_hold_in_mult", {24'b0, ACC}, {24'b0, prev});
      if (ev_kind == 1 && guard == ev_at) begin
        Start = 1'b1; Op = 3'd0; SW = 8'd5;
        SelSW = 1'b1; SelImm = 1'b0; SelRegData = 1'b0;
      end else begin
        Start = 1'b0;
      end
      if (ev_kind == 2 && guard == ev_at) begin
        nReset = 1'b0;
        #1;
        check("rst_acc", {24'b0, ACC}, 32'd0);
        check("rst_busy", {31'b0, Busy}, 32'd0);
        check("rst_done", {31'b0, Done}, 32'd0);
        exp_q.delete();
        model_acc = '0;
        @(negedge Clock);
        nReset = 1'b1;
        return;
      end
      @(negedge Clock);
      guard++;
    end
    Start = 1'b0;
    check("mul_done_seen", {31'b0, guard < 4 * W}, 32'd1);
    check("busy_cycles", n, W + 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish required finish before timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge Clock);
    check("reset_acc", {24'b0, ACC}, 32'd0);
    check("reset_busy", {31'b0, Busy}, 32'd0);
    check("reset_done", {31'b0, Done}, 32'd0);
    nReset = 1'b1;
    @(negedge Clock);

    run_op(3'd3, 8'd24, 8'd16, 8'd0, 1'b0, 1'b0, 1'b1, -1, 0);
    check("tp_mul_48", {24'b0, ACC}, 32'h30);
    run_op(3'd0, 8'd8, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, -1, 0);
    run_op(3'd4, 8'd24, 8'd0, 8'hF8, 1'b0, 1'b1, 1'b0, -1, 0);
    check("tp_mac_f0", {24'b0, ACC}, 32'hF0);
    run_op(3'd0, 8'd100, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, -1, 0);
    run_op(3'd1, 8'd100, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, -1, 0);
`ifdef ACC_ALU_SAT_EN
    check("tp_add_sat", {24'b0, ACC}, 32'h7F);
`else
    check("tp_add_wrap", {24'b0, ACC}, 32'hC8);
`endif
    run_op(3'd3, 8'd16, 8'd12, 8'd0, 1'b0, 1'b0, 1'b1, 3, 1);
    check("tp_start_ignored", {24'b0, ACC}, 32'h18);
    run_op(3'd3, 8'd24, 8'd16, 8'd0, 1'b0, 1'b0, 1'b1, 4, 2);
    run_op(3'd0, 8'd7, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, -1, 0);
    check("tp_load_after_rst", {24'b0, ACC}, 32'd7);
    run_op(3'd0, 8'h55, 8'h66, 8'h77, 1'b0, 1'b0, 1'b0, -1, 0);
    check("tp_no_select", {24'b0, ACC}, 32'd0);
    run_op(3'd0, 8'h0F, 8'h00, 8'hF0, 1'b1, 1'b1, 1'b0, -1, 0);
    check("tp_or_select", {24'b0, ACC}, 32'hFF);

    for (int i = 0; i < 120; i++) begin
      run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), -1, 0);
      if ($urandom_range(0, 3) == 0) @(negedge Clock);
    end

    repeat (3) @(negedge Clock);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_alu_seq.md
# acc_alu_seq

Parametrised accumulator ALU for the next picoMips core, replacing the single-cycle 8-bit multiply-accumulate datapath. Supports load, add, subtract, clear, fixed-point multiply and multiply-accumulate on a `WIDTH`-bit signed accumulator. Multiplies run on a radix-2 sequential shift-add engine, so the block needs no full-width array multiplier. The decoder talks to it through a Start/Busy/Done handshake.

## Interface
- `WIDTH`, 8: datapath and accumulator width in bits (≥4).
- `FRAC`, 3: fraction bits of the fixed-point format; the multiply result is arithmetic-shifted right by `FRAC` (0 ≤ `FRAC` < `WIDTH`).
- `Clock`  in  1  single clock, rising edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  request; sampled only when `Busy`=0.
- `Op`  in  3  operation code: 0 LOAD, 1 ADD, 2 SUB, 3 MUL, 4 MAC, 5 CLR, 6–7 NOP.
- `Imm`  in  WIDTH  sign-extended immediate; also the multiplier operand.
- `RegData`  in  WIDTH  register-file read data.
- `SW`  in  WIDTH  input switches.
- `SelImm`, `SelSW`, `SelRegData`  in  1 each  operand source selects.
- `Busy`  out  1  block is executing a multiply; reset 0.
- `Done`  out  1  one-cycle completion pulse; reset 0.
- `ACC`  out  WIDTH  accumulator; reset 0.

## Operation
- Operand `data` = (`Imm` & {`SelImm`}) | (`SW` & {`SelSW`}) | (`RegData` & {`SelRegData`}).
  - With no select asserted, `data` is 0.
  - With several selects asserted, `data` is the OR of the selected sources.
- `Op`, `data`, `Imm` and `ACC` are captured on the accepting edge. Later input changes do not affect an operation in flight.
- Single-cycle operations:
  - LOAD: `ACC` ← `data`.
  - ADD: `ACC` ← `ACC` + `data`.
  - SUB: `ACC` ← `ACC` − `data`.
  - CLR: `ACC` ← 0.
  - NOP: `ACC` unchanged, but `Done` still pulses.
- Multiply operations:
  - P = signed(`data`) × signed(`Imm`), exact 2·WIDTH-bit two's-complement product.
  - S = P >>> `FRAC`, with the low WIDTH bits kept.
  - MUL: `ACC` ← S.
  - MAC: `ACC` ← `ACC`_captured + S.
- Multiply engine: one partial-product step per cycle, WIDTH steps. The final step subtracts, for sign correction of the multiplier MSB.
- Arithmetic wraps modulo 2^WIDTH unless saturation is configured (see Configuration).
- FSM states:
  - IDLE: `Busy`=0. Start with `Op`∈{3,4} → MULT; any other Start executes in place and stays in IDLE.
  - MULT: `Busy`=1, step counter 0..WIDTH−1. After the last step → WB.
  - WB: `Busy`=1. Writes `ACC` → IDLE.

## Timing
- Edge E0 is the edge that samples `Start`=1 in IDLE.
- Single-cycle operation:
  - `ACC` holds the new value after E0.
  - `Done`=1 for exactly the cycle after E0.
  - `Busy` stays 0.
- Multiply:
  - `Busy`=1 from after E0 until after edge E0+WIDTH+1.
  - `ACC` is written at E0+WIDTH+1, so the latency is WIDTH+1 cycles.
  - `Done`=1 for the single cycle after E0+WIDTH+1.
  - `ACC` keeps its old value throughout MULT.
- `Start` while `Busy`=1 is ignored and not queued.
- `Start` in the cycle where `Done`=1 is accepted, allowing back-to-back operations.
- `nReset` low at any time takes effect immediately:
  - aborts MULT/WB;
  - state → IDLE, `ACC`=0, `Busy`=0, `Done`=0;
  - discards the partial product.
- `Done` and `Busy` are registered outputs. There is no combinational path from inputs to outputs.

## Configuration
- `ACC_ALU_SAT_EN` defined:
  - ADD, SUB, MUL and MAC clamp to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - MUL/MAC saturation is judged on the full shifted product and the full sum, before truncation.
- `ACC_ALU_SAT_EN` undefined: all results wrap modulo 2^WIDTH, and no saturation logic is synthesised.
- Timing and handshake are identical in both builds.

## Test plan
All cases use `WIDTH`=8, `FRAC`=3.
- MUL, `SelRegData`, `RegData`=16, `Imm`=24 → `Busy` high 9 cycles, `ACC`=48 (0x30), `Done` pulse 10 cycles after E0.
- MAC with `ACC`=8, `SelSW`, `SW`=−8 (0xF8), `Imm`=24 → `ACC`=8−24=−16 (0xF0).
- LOAD 100, then ADD 100 back-to-back:
  - without macro → `ACC`=0xC8 (−56);
  - with `ACC_ALU_SAT_EN` → `ACC`=0x7F.
  - `Done` pulses on consecutive cycles.
- Start MUL, then assert `Start` with LOAD 5 at cycle 3 → LOAD ignored, final `ACC`=MUL result, one `Done` pulse only.
- Start MUL, pull `nReset` low at cycle 4 → `ACC`=0, `Busy`=0 and `Done`=0 immediately; after release, LOAD 7 completes normally with `ACC`=7.
- No select asserted with LOAD → `ACC`=0. `SelImm` and `SelSW` both asserted, `Imm`=0x0F, `SW`=0xF0 → `ACC`=0xFF.
